// File: rtl/cpu_state_sequencer_if.sv
// cpu_state_sequencer_if
// Groups the sequencer's memory-unit handshake, datapath and status signals.
//   slave  : sequencer side (takes stall/data inputs, drives strobes/status)
//   master : environment side (memory access unit, ALU, PC, test bench)
// Inputs to sequencer : mem_halt, alu_busy, pc_address[31:0], dataout[31:0]
// Outputs             : fetch, exec1, exec2, instr_reg[31:0], load_data[31:0],
//                       pc_update, reg_write_strobe, active,
//                       pc_reset_value[31:0], state[1:0]
// Optional macro CPU_STATE_SEQUENCER_RETIRE_COUNT_EN adds retired_count[31:0].
interface cpu_state_sequencer_if;
    logic        mem_halt;
    logic        alu_busy;
    logic [31:0] pc_address;
    logic [31:0] dataout;
    logic        fetch;
    logic        exec1;
    logic        exec2;
    logic [31:0] instr_reg;
    logic [31:0] load_data;
    logic        pc_update;
    logic        reg_write_strobe;
    logic        active;
    logic [31:0] pc_reset_value;
    logic [1:0]  state;
`ifdef CPU_STATE_SEQUENCER_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    modport slave (
        input  mem_halt, alu_busy, pc_address, dataout,
        output fetch, exec1, exec2, instr_reg, load_data, pc_update,
               reg_write_strobe, active, pc_reset_value, state
`ifdef CPU_STATE_SEQUENCER_RETIRE_COUNT_EN
        , output retired_count
`endif
    );

    modport master (
        output mem_halt, alu_busy, pc_address, dataout,
        input  fetch, exec1, exec2, instr_reg, load_data, pc_update,
               reg_write_strobe, active, pc_reset_value, state
`ifdef CPU_STATE_SEQUENCER_RETIRE_COUNT_EN
        , input retired_count
`endif
    );
endinterface

// File: rtl/cpu_state_sequencer.sv
// cpu_state_sequencer
// Multi-cycle CPU control sequencer feeding the memory access unit.
// Produces one-hot FETCH/EXEC1/EXEC2 strobes, latches the instruction word
// and EXEC1 load data, pulses PC-update/register-write in EXEC2 and stops
// for good (until reset) when a fetch from HALT_ADDRESS is attempted.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : cpu_state_sequencer_if.slave (stall/data in, strobes/status out)
// Optional macro CPU_STATE_SEQUENCER_RETIRE_COUNT_EN: adds a 32-bit
// retired-instruction counter (one count per EXEC2 cycle, wraps).
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | read instruction word; halts instead if PC == HALT_ADDRESS
// EXEC1   | memory/ALU phase; waits out mem_halt and alu_busy
// EXEC2   | writeback; PC update and register write, always one cycle
// HALTED  | sticky stop, all strobes low, left only by reset
module cpu_state_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_state_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC1  = 2'd1,
        S_EXEC2  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] load_q,  load_d;
`ifdef CPU_STATE_SEQUENCER_RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            instr_q <= '0;
            load_q  <= '0;
`ifdef CPU_STATE_SEQUENCER_RETIRE_COUNT_EN
            retired_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            load_q  <= load_d;
`ifdef CPU_STATE_SEQUENCER_RETIRE_COUNT_EN
            retired_q <= retired_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        load_d  = load_q;
        case (state_q)
            S_FETCH: begin
                if (bus.pc_address == HALT_ADDRESS) begin
                    state_d = S_HALTED;
                end else if (!bus.mem_halt) begin
                    instr_d = bus.dataout;
                    state_d = S_EXEC1;
                end
            end
            S_EXEC1: begin
                // Both stall sources must be clear before data is taken.
                if (!bus.mem_halt && !bus.alu_busy) begin
                    load_d  = bus.dataout;
                    state_d = S_EXEC2;
                end
            end
            // No memory access is issued in EXEC2, so mem_halt is ignored.
            S_EXEC2:  state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

`ifdef CPU_STATE_SEQUENCER_RETIRE_COUNT_EN
    // Natural 32-bit wrap; HALTED never reaches EXEC2 so the count freezes.
    assign retired_d = retired_q + {31'd0, (state_q == S_EXEC2)};
`endif

    always_comb begin
        // Fetch is gated so no read is issued for the halt address.
        bus.fetch            = (state_q == S_FETCH) && (bus.pc_address != HALT_ADDRESS);
        bus.exec1            = (state_q == S_EXEC1);
        bus.exec2            = (state_q == S_EXEC2);
        bus.pc_update        = (state_q == S_EXEC2);
        bus.reg_write_strobe = (state_q == S_EXEC2);
        bus.active           = (state_q != S_HALTED);
        bus.instr_reg        = instr_q;
        bus.load_data        = load_q;
        bus.pc_reset_value   = RESET_VECTOR;
        bus.state            = state_q;
`ifdef CPU_STATE_SEQUENCER_RETIRE_COUNT_EN
        bus.retired_count    = retired_q;
`endif
    end

endmodule

// File: doc/cpu_state_sequencer.md
Name: cpu_state_sequencer

Overview:
- Multi-cycle CPU control sequencer that sits directly upstream of the memory access unit.
- Generates the one-hot phase strobes fetch/exec1/exec2 that the memory access unit consumes, and stalls on its mem_halt output.
- Latches the fetched instruction word and the EXEC1 load data, and emits PC-update and register-write strobes.
- Detects the halt condition (fetch from address 0) and drives the CPU-level active flag.

Parameters:
- RESET_VECTOR, 32'hBFC00000, value reported on pc_reset_value for the PC register to load on reset.
- HALT_ADDRESS, 32'h00000000, a fetch from this address halts the CPU.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mem_halt  input  1  memory stall from the memory access unit (read/write pending with waitrequest high)
- alu_busy  input  1  multi-cycle ALU operation (mult/div) still running
- pc_address  input  32  current PC value
- dataout  input  32  decoded memory data from the memory access unit
- fetch  output  1  FETCH phase strobe
- exec1  output  1  EXEC1 phase strobe
- exec2  output  1  EXEC2 phase strobe
- instr_reg  output  32  latched instruction word
- load_data  output  32  data latched at the end of EXEC1
- pc_update  output  1  one-cycle pulse in EXEC2, PC advances
- reg_write_strobe  output  1  one-cycle pulse in EXEC2, register file write allowed
- active  output  1  high while not halted
- pc_reset_value  output  32  constant RESET_VECTOR
- state  output  2  encoded state, for debug and testbench

Behaviour:
- States (encoding): FETCH=2'd0, EXEC1=2'd1, EXEC2=2'd2, HALTED=2'd3.
- Reset (synchronous, takes priority over everything, including mid-stall and HALTED):
  - state=FETCH, instr_reg=0, load_data=0, active=1.
  - Strobes follow the state, so fetch=1 and all others are 0 in the first cycle after reset.
- Outputs are a decode of the registered state:
  - fetch = (state==FETCH) && (pc_address!=HALT_ADDRESS).
  - exec1 = (state==EXEC1); exec2 = (state==EXEC2).
  - pc_update = reg_write_strobe = (state==EXEC2).
  - active = (state!=HALTED).
- FETCH:
  - pc_address==HALT_ADDRESS → HALTED next cycle. No read is issued because fetch is gated low.
  - Else, mem_halt=1 → stay in FETCH, instr_reg holds.
  - Else → instr_reg<=dataout, go to EXEC1.
- EXEC1:
  - mem_halt=1 or alu_busy=1 → stay in EXEC1, load_data holds.
  - Else → load_data<=dataout, go to EXEC2.
  - mem_halt and alu_busy asserted together: stay until both are low.
- EXEC2: unconditional → FETCH. mem_halt is ignored because no memory access is issued in EXEC2.
- HALTED: sticky. All strobes 0, active=0; only reset leaves this state.
- Latency: 3 cycles per instruction with zero wait states. Each cycle of mem_halt or alu_busy adds one cycle.
- instr_reg is stable from EXEC1 through the next FETCH completion. load_data is valid throughout EXEC2.
- Exactly one of fetch/exec1/exec2 is high outside HALTED; none is high in HALTED.

Optional Feature:
- Macro: CPU_STATE_SEQUENCER_RETIRE_COUNT_EN.
- When defined:
  - Adds output retired_count [31:0], reset to 0, incremented by 1 on every cycle with state==EXEC2.
  - Wraps from 32'hFFFFFFFF to 0. Frozen in HALTED.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset then no stalls, pc_address=32'hBFC00000, dataout=32'h24020005 in FETCH → state sequence 0,1,2,0; instr_reg=32'h24020005 from cycle 2; pc_update pulses once in cycle 3.
- mem_halt high for 3 cycles in FETCH → fetch stays high 4 cycles; instr_reg captures dataout only on the cycle mem_halt=0; EXEC1 entered on the following cycle.
- In EXEC1, alu_busy high 5 cycles and mem_halt high during cycles 2-3 → exec1 held 6 cycles; load_data=dataout sampled in the last exec1 cycle (e.g. 32'h0000ABCD); a single exec2 pulse follows.
- pc_address=0 in FETCH → fetch=0 that cycle; HALTED next cycle with active=0; held for 20 cycles of arbitrary stimulus.
- reset asserted in HALTED and separately mid-EXEC1 stall → next cycle state=FETCH, active=1, instr_reg=0, load_data=0.
- With CPU_STATE_SEQUENCER_RETIRE_COUNT_EN: 10 unstalled instructions → retired_count=10; reset → 0; preload scenario reaching 32'hFFFFFFFF plus one more EXEC2 → 0.
